// File: rtl/conv_pass_sequencer.sv
// conv_pass_sequencer: control FSM that sequences convolution passes over a pixel tile.
//
// For each pass (kernel/bias bank) and each output pixel, the FSM steps through:
//   PRIME   - one cycle for ROM / kernel-register latency
//   ACCUM   - CHIN accepted input words, stalling while ifm_valid is low
//   CAPTURE - one cycle in which bias+ReLU is captured and the accumulators are cleared
//   OUTPUT  - holds the result vector until the sink accepts it
//
// Parameters:
//   CHIN   - input channels accumulated per output pixel
//   PIXELS - output pixels per pass
//   PASSES - bank passes per run (bank_sel is one bit wide, so at most 2)
//
// Ports:
//   clk, rst                - clock; asynchronous active-high reset
//   start                   - run request, honoured only while idle
//   ifm_valid               - input word present at ifm_addr
//   ofm_ready               - result sink accepts the vector
//   ifm_addr                - pix_idx*CHIN + ch_idx
//   weight_addr             - ch_idx, shared by both weight ROMs
//   bank_sel                - pass index (0 = layer-1 bank, 1 = layer-2 bank)
//   mac_en, mac_clr         - MAC accumulate enable and accumulator clear
//   ofm_capture             - datapath registers bias+ReLU of the accumulators
//   ofm_valid, ofm_pix      - result vector valid, and its pixel index
//   busy                    - a run is in progress
//   pass_done, run_done     - one-cycle pulses at the end of each pass and of the run
//   stall_cycles            - present only when CONV_SEQ_PERF_EN is defined; counts
//                             input-starved ACCUM cycles plus back-pressured OUTPUT
//                             cycles, saturating at all-ones
module conv_pass_sequencer #(
    parameter int CHIN   = 736,
    parameter int PIXELS = 64,
    parameter int PASSES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ifm_valid,
    input  logic        ofm_ready,
    output logic [15:0] ifm_addr,
    output logic [9:0]  weight_addr,
    output logic        bank_sel,
    output logic        mac_en,
    output logic        mac_clr,
    output logic        ofm_capture,
    output logic        ofm_valid,
    output logic [5:0]  ofm_pix,
    output logic        busy,
    output logic        pass_done,
    output logic        run_done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    typedef enum logic [2:0] {IDLE, PRIME, ACCUM, CAPTURE, OUTPUT} state_t;
    state_t      state;
    logic [9:0]  ch_idx;
    logic [5:0]  pix_idx;
    logic        pass_idx;
    logic [15:0] pix_base;

    // pix_base tracks pix_idx*CHIN incrementally, so no multiplier is needed
    assign ifm_addr    = pix_base + 16'(ch_idx);
    assign weight_addr = ch_idx;
    assign ofm_pix     = pix_idx;
    assign bank_sel    = pass_idx;
    // mac_en follows ifm_valid in the same cycle, so it cannot be registered
    assign mac_en      = (state == ACCUM) && ifm_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch_idx      <= '0;
            pix_idx     <= '0;
            pass_idx    <= 1'b0;
            pix_base    <= '0;
            busy        <= 1'b0;
            mac_clr     <= 1'b0;
            ofm_capture <= 1'b0;
            ofm_valid   <= 1'b0;
            pass_done   <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            pass_done   <= 1'b0;
            run_done    <= 1'b0;
            mac_clr     <= 1'b0;
            ofm_capture <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= PRIME;
                    busy     <= 1'b1;
                    ch_idx   <= '0;
                    pix_idx  <= '0;
                    pass_idx <= 1'b0;
                    pix_base <= '0;
                end
                PRIME: state <= ACCUM;
                ACCUM: if (ifm_valid) begin
                    if (ch_idx == 10'(CHIN - 1)) begin
                        ch_idx      <= '0;
                        state       <= CAPTURE;
                        mac_clr     <= 1'b1;
                        ofm_capture <= 1'b1;
                    end else begin
                        ch_idx <= ch_idx + 10'd1;
                    end
                end
                CAPTURE: begin
                    state     <= OUTPUT;
                    ofm_valid <= 1'b1;
                end
                OUTPUT: if (ofm_ready) begin
                    ofm_valid <= 1'b0;
                    state     <= PRIME;
                    if (pix_idx == 6'(PIXELS - 1)) begin
                        pass_done <= 1'b1;
                        pix_idx   <= '0;
                        pix_base  <= '0;
                        if (pass_idx == 1'(PASSES - 1)) begin
                            pass_idx <= 1'b0;
                            run_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            pass_idx <= pass_idx + 1'b1;
                        end
                    end else begin
                        pix_idx  <= pix_idx + 6'd1;
                        pix_base <= pix_base + 16'(CHIN);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (state == IDLE && start)
            stall_cycles <= '0;
        else if (((state == ACCUM && !ifm_valid) || (state == OUTPUT && !ofm_ready)) && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule
